ysyx_22051013_ifu_fetch: RTL

//  Instruction fetch unit: owns the architectural PC and fetches 32-bit instructions from a 64-bit instruction port.

---
 rtl/ysyx_22051013_ifu_fetch_if.sv | 27 ++
 rtl/ysyx_22051013_ifu_fetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/ysyx_22051013_ifu_fetch_if.sv
// Instruction-memory port of the fetch unit: one request channel, one response channel.
// The fetch unit is the master; the memory (or its adapter) is the slave.
interface ysyx_22051013_ifu_fetch_if #(
   parameter int XLEN = 64
) ();
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [63:0]     imem_resp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_resp_valid,
      input  imem_resp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_resp_valid,
      output imem_resp_data
   );
endinterface

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one 64-bit fetch at a time, hands {pc, inst}
// to decode over valid/ready, and squashes fetches made stale by a jump redirect.
module ysyx_22051013_ifu_fetch #(
   parameter int              XLEN     = 64,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h0000_0000_8000_0000)
) (
   input  logic                                clk,
   input  logic                                rst,
   ysyx_22051013_ifu_fetch_if.master           imem,
   input  logic                                jump_i,
   input  logic [XLEN-1:0]                     jump_pc_i,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [XLEN-1:0]                     pc_o,
   output logic [31:0]                         inst_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] req_pc;
   logic            drop;
   logic            drop_nxt;
   logic            out_valid_nxt;
   logic            capture;
   logic            enter_req;
   logic [XLEN-1:0] jump_tgt;

   assign jump_tgt = jump_pc_i & ~XLEN'(3);

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      drop_nxt      = drop;
      out_valid_nxt = out_valid;
      capture       = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = S_REQ;
            if (jump_i) pc_nxt = jump_tgt;
         end
         S_REQ: begin
            // The request already on the bus cannot be withdrawn; mark its response for discard.
            if (jump_i) begin
               pc_nxt   = jump_tgt;
               drop_nxt = 1'b1;
            end
            if (imem.imem_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (jump_i) begin
               pc_nxt   = jump_tgt;
               drop_nxt = 1'b1;
            end
            if (imem.imem_resp_valid) begin
               if (drop || jump_i) begin
                  drop_nxt  = 1'b0;
                  state_nxt = S_REQ;
               end else begin
                  capture       = 1'b1;
                  out_valid_nxt = 1'b1;
                  state_nxt     = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            // A jump wins over the sequential pc+4 whether or not decode took the instruction.
            if (jump_i) begin
               pc_nxt        = jump_tgt;
               out_valid_nxt = 1'b0;
               state_nxt     = S_REQ;
            end else if (out_ready) begin
               pc_nxt        = pc + XLEN'(4);
               out_valid_nxt = 1'b0;
               state_nxt     = S_REQ;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign enter_req = (state_nxt == S_REQ) && (state != S_REQ);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         pc        <= RESET_PC;
         req_pc    <= RESET_PC;
         drop      <= 1'b0;
         out_valid <= 1'b0;
         pc_o      <= RESET_PC;
         inst_o    <= 32'd0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         drop      <= drop_nxt;
         out_valid <= out_valid_nxt;
         if (enter_req) req_pc <= pc_nxt;
         if (capture) begin
            inst_o <= req_pc[2] ? imem.imem_resp_data[63:32] : imem.imem_resp_data[31:0];
            pc_o   <= req_pc;
         end
      end
   end

   assign imem.imem_req_valid = (state == S_REQ);
   assign imem.imem_req_addr  = {req_pc[XLEN-1:3], 3'b000};

endmodule
